// File: rtl/coax_pkg.sv
// Shared definitions for the buffered coax host interface.
package coax_pkg;

  localparam int DATA_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/coax_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy/flags.
module coax_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_pop;
  logic             w_do_push;
  logic [CW-1:0]    w_count_nxt;

  // A push into a full FIFO is legal when the same cycle frees a slot.
  assign w_do_pop    = pop && !r_empty;
  assign w_do_push   = push && (!r_full || w_do_pop);
  assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/coax_buffered_interface.sv
// Host-side TX/RX buffering between the host bus and the coax_tx/coax_rx pair,
// with stream or commit-then-burst transmit and sticky RX overflow.
module coax_buffered_interface
  import coax_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_tx_write,
  input  logic [DATA_WIDTH-1:0]     host_tx_data,
  input  logic                      host_tx_commit,
  input  logic                      tx_burst,
  output logic                      host_tx_full,
  output logic [$clog2(TX_DEPTH):0] host_tx_count,
  input  logic                      host_rx_read,
  output logic [DATA_WIDTH-1:0]     host_rx_data,
  output logic                      host_rx_empty,
  output logic [$clog2(RX_DEPTH):0] host_rx_count,
  output logic                      host_rx_overflow,
  input  logic                      host_overflow_clear,
  output logic                      tx_load,
  output logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_full,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_data_available,
  output logic                      rx_data_read
);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic                  w_tx_push;
  logic                  w_tx_empty;
  logic [DATA_WIDTH-1:0] w_tx_head;
  logic                  w_tx_load_nxt;
  logic                  r_tx_load;
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic                  w_rx_capture;
  logic                  w_rx_full;
  logic                  w_rx_drop;
  logic                  r_rx_data_read;
  logic [DATA_WIDTH-1:0] r_rx_word;
  logic                  r_rx_overflow;

  assign w_tx_push = host_tx_write && !host_tx_full;

  coax_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .wdata (host_tx_data),
    .pop   (w_tx_load_nxt),
    .rdata (w_tx_head),
    .full  (host_tx_full),
    .empty (w_tx_empty),
    .count (host_tx_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= TX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Leaving IDLE counts the word being written this cycle, so a write reaches SEND one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE: if ((w_tx_push || !w_tx_empty) && (!tx_burst || host_tx_commit))
                 w_state_nxt = TX_SEND;
      TX_SEND: if (w_tx_empty)   w_state_nxt = TX_IDLE;
               else if (!tx_full) w_state_nxt = TX_GAP;
      TX_GAP:  w_state_nxt = TX_SEND;
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_load_nxt = (r_state == TX_SEND) && !w_tx_empty && !tx_full;
  end

  always_ff @(posedge clk) begin
    if (reset) r_tx_load <= 1'b0;
    else       r_tx_load <= w_tx_load_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_tx_load_nxt) r_tx_data <= w_tx_head;
  end

  // The word is latched on capture and pushed while rx_data_read is high.
  assign w_rx_capture = rx_data_available && !r_rx_data_read;
  assign w_rx_drop    = r_rx_data_read && w_rx_full && !host_rx_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data_read <= 1'b0;
      r_rx_overflow  <= 1'b0;
    end else begin
      r_rx_data_read <= w_rx_capture;
      if (w_rx_drop)                r_rx_overflow <= 1'b1;
      else if (host_overflow_clear) r_rx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_capture) r_rx_word <= rx_data;
  end

  coax_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_rx_data_read),
    .wdata (r_rx_word),
    .pop   (host_rx_read),
    .rdata (host_rx_data),
    .full  (w_rx_full),
    .empty (host_rx_empty),
    .count (host_rx_count)
  );

  assign tx_load          = r_tx_load;
  assign tx_data          = r_tx_data;
  assign rx_data_read     = r_rx_data_read;
  assign host_rx_overflow = r_rx_overflow;

endmodule
